// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if
//   Bundles the run-control handshake between the decoder's top-level control,
//   the countdown Timer and the timer_sequencer.
//   master : control side (drives start/mode_sel/pause/abort/answer_done and the
//            Timer's timeout_1sec), observes all sequencer outputs.
//   slave  : the sequencer itself.
interface timer_sequencer_if;
  logic       start;
  logic [1:0] mode_sel;
  logic       pause;
  logic       abort;
  logic       answer_done;
  logic       timeout_1sec;
  logic       timer_enable;
  logic       timer_reconfig;
  logic [1:0] timer_mode;
  logic [6:0] secs_left;
  logic       busy;
  logic       warn;
  logic       time_up;
  logic       answered;

  modport master (
    output start, mode_sel, pause, abort, answer_done, timeout_1sec,
    input  timer_enable, timer_reconfig, timer_mode, secs_left,
           busy, warn, time_up, answered
  );

  modport slave (
    input  start, mode_sel, pause, abort, answer_done, timeout_1sec,
    output timer_enable, timer_reconfig, timer_mode, secs_left,
           busy, warn, time_up, answered
  );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Run-control FSM for the Morse decoder's countdown Timer. Loads the round
//   length into the Timer (timer_reconfig/timer_mode), gates timer_enable and
//   keeps a seconds-remaining shadow count driven by timeout_1sec edges. A round
//   ends on expiry (time_up) or on an early answer (answered).
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : timer_sequencer_if.slave
//          in  start, mode_sel[1:0], pause, abort, answer_done, timeout_1sec
//          out timer_enable, timer_reconfig, timer_mode[1:0], secs_left[6:0],
//              busy, warn, time_up, answered
//   All outputs are registered.
module timer_sequencer #(
  parameter int SECS_MODE0      = 30,
  parameter int SECS_MODE1      = 20,
  parameter int SECS_MODE2      = 10,
  parameter int SECS_MODE3      = 5,
  parameter int RECONFIG_CYCLES = 2,
  parameter int WARN_SECS       = 5
) (
  input  logic               clk,
  input  logic               rst,
  timer_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_PAUSED, S_DONE
  } state_t;

  localparam int         CW     = (RECONFIG_CYCLES > 1) ? $clog2(RECONFIG_CYCLES) : 1;
  localparam logic [6:0] WARN_L = 7'(WARN_SECS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;
  logic [1:0]    mode_q, mode_d;
  logic [6:0]    secs_q, secs_d;
  logic          en_q, rcfg_q, busy_q, warn_q, time_up_q, answered_q;
  logic          time_up_d, answered_d;
  logic          tmo_edge;

  function automatic logic [6:0] round_secs(input logic [1:0] m);
    case (m)
      2'b00:   return 7'(SECS_MODE0);
      2'b01:   return 7'(SECS_MODE1);
      2'b10:   return 7'(SECS_MODE2);
      default: return 7'(SECS_MODE3);
    endcase
  endfunction

  // tmo_q samples timeout_1sec every cycle regardless of state, so a level
  // that is still high after a state change is not seen as a fresh second.
  assign tmo_edge = bus.timeout_1sec & ~tmo_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    secs_d     = secs_q;
    time_up_d  = 1'b0;
    answered_d = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      secs_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            mode_d  = bus.mode_sel;
            secs_d  = round_secs(bus.mode_sel);
            cnt_d   = CW'(RECONFIG_CYCLES - 1);
          end
        end
        S_LOAD: begin
          // reconfig is already high for the cycle after accept; the counter
          // holds the number of additional LOAD cycles still owed.
          if (cnt_q == '0) state_d = S_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_RUN: begin
          if (bus.answer_done) begin
            state_d    = S_DONE;
            answered_d = 1'b1;
          end else if (tmo_edge) begin
            // <=1 rather than ==1 so a zero count can never wrap.
            if (secs_q <= 7'd1) begin
              secs_d    = '0;
              time_up_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              secs_d = secs_q - 7'd1;
            end
          end else if (bus.pause) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (bus.answer_done) begin
            state_d    = S_DONE;
            answered_d = 1'b1;
          end else if (!bus.pause) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      mode_q     <= '0;
      secs_q     <= '0;
      en_q       <= 1'b0;
      rcfg_q     <= 1'b0;
      busy_q     <= 1'b0;
      warn_q     <= 1'b0;
      time_up_q  <= 1'b0;
      answered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= bus.timeout_1sec;
      mode_q     <= mode_d;
      secs_q     <= secs_d;
      // Outputs are decoded from next state so they line up with state_q.
      en_q       <= (state_d == S_RUN);
      rcfg_q     <= (state_d == S_LOAD);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSED);
      warn_q     <= ((state_d == S_RUN) || (state_d == S_PAUSED)) &&
                    (secs_d != '0) && (secs_d <= WARN_L);
      time_up_q  <= time_up_d;
      answered_q <= answered_d;
    end
  end

  assign bus.timer_enable   = en_q;
  assign bus.timer_reconfig = rcfg_q;
  assign bus.timer_mode     = mode_q;
  assign bus.secs_left      = secs_q;
  assign bus.busy           = busy_q;
  assign bus.warn           = warn_q;
  assign bus.time_up        = time_up_q;
  assign bus.answered       = answered_q;

endmodule
